// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Bus ownership. OWN_CORE is also used to record the last core grant.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CORE   = 2'd1,
        OWN_LOADER = 2'd2
    } owner_t;

    // Default number of consecutive locked loader grants before the core may force a release
    localparam int unsigned DMEM_MAX_HOLD = 8;

    // Width of the hold counter
    localparam int unsigned HOLD_WIDTH = 8;

    // Saturating increment so a long uncontested lock never wraps back below the limit
    function automatic logic [HOLD_WIDTH-1:0] hold_inc(input logic [HOLD_WIDTH-1:0] cnt);
        logic [HOLD_WIDTH-1:0] res;
        res = (cnt == {HOLD_WIDTH{1'b1}}) ? cnt : cnt + 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector. Index 0 is the core, index 1 the loader.
// last_i=1 means the loader held the previous grant, so the core wins a tie.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // One-hot grant: a lone requester always wins, a tie goes to whoever was not last
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core load/store path and a loader/debug master.
// Grants are combinational; a granted access completes in the same cycle and read data
// is returned from a register one cycle later.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CTRL_WIDTH = 3,
    parameter int unsigned MAX_HOLD   = DMEM_MAX_HOLD
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  c_req_i,
    input  logic                  c_we_i,
    input  logic [ADDR_WIDTH-1:0] c_addr_i,
    input  logic [DATA_WIDTH-1:0] c_wdata_i,
    input  logic [CTRL_WIDTH-1:0] c_ctrl_i,
    output logic                  c_gnt_o,
    output logic                  c_stall_o,

    input  logic                  l_req_i,
    input  logic                  l_lock_i,
    input  logic                  l_we_i,
    input  logic [ADDR_WIDTH-1:0] l_addr_i,
    input  logic [DATA_WIDTH-1:0] l_wdata_i,
    input  logic [CTRL_WIDTH-1:0] l_ctrl_i,
    output logic                  l_gnt_o,

    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  c_rvalid_o,
    output logic                  l_rvalid_o,

    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_we_o,
    output logic [CTRL_WIDTH-1:0] mem_ctrl_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [HOLD_WIDTH-1:0] MaxHold = HOLD_WIDTH'(MAX_HOLD);

    owner_t                owner_q, owner_d;
    owner_t                last_q, last_d;
    logic [HOLD_WIDTH-1:0] hold_q, hold_d;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  c_rvalid_q;
    logic                  l_rvalid_q;

    logic                  c_gnt;
    logic                  l_gnt;
    logic                  lock_keep;
    logic                  hold_done;
    logic [1:0]            rr_req;
    logic [1:0]            rr_gnt;

    // Round-robin between the two masters whenever no lock is being honoured
    assign rr_req = {l_req_i, c_req_i};

    rr_pick2 u_pick (
        .req_i  (rr_req),
        .last_i (last_q == OWN_LOADER),
        .gnt_o  (rr_gnt)
    );

    // The lock survives while the loader keeps asking for it, unless the hold budget is
    // spent and the core is waiting. Every locked grant records the loader as last, so on
    // any release the core wins the tie; that alone keeps the loader out until the core
    // has had its grant after a forced release.
    assign hold_done = (hold_q >= MaxHold);
    assign lock_keep = (owner_q == OWN_LOADER) && l_req_i && l_lock_i && !(hold_done && c_req_i);

    // State register: ownership, round-robin pointer and hold counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q <= OWN_NONE;
            last_q  <= OWN_LOADER;
            hold_q  <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Next state: a granted locking loader takes (or keeps) the bus, anything else frees it
    always_comb begin
        owner_d = OWN_NONE;
        last_d  = last_q;
        hold_d  = '0;

        if (c_gnt) begin
            last_d = OWN_CORE;
        end else if (l_gnt) begin
            last_d = OWN_LOADER;
        end

        if (l_gnt && l_lock_i) begin
            owner_d = OWN_LOADER;
            // The acquiring grant counts as the first held grant
            hold_d  = lock_keep ? hold_inc(hold_q) : HOLD_WIDTH'(1);
        end
    end

    // Grant decode: held lock first, otherwise round-robin; nothing is granted in reset
    always_comb begin
        c_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!rst_i) begin
            if (lock_keep) begin
                l_gnt = 1'b1;
            end else begin
                c_gnt = rr_gnt[0];
                l_gnt = rr_gnt[1];
            end
        end
    end

    // Memory port mux: route the granted master, drive zeros when idle
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        mem_ctrl_o  = '0;
        if (c_gnt) begin
            mem_addr_o  = c_addr_i;
            mem_wdata_o = c_wdata_i;
            mem_we_o    = c_we_i;
            mem_ctrl_o  = c_ctrl_i;
        end else if (l_gnt) begin
            mem_addr_o  = l_addr_i;
            mem_wdata_o = l_wdata_i;
            mem_we_o    = l_we_i;
            mem_ctrl_o  = l_ctrl_i;
        end
    end

    // Read return path: capture data on a granted read, tag it with its owner for one cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q    <= '0;
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
        end else begin
            c_rvalid_q <= c_gnt && !c_we_i;
            l_rvalid_q <= l_gnt && !l_we_i;
            if ((c_gnt && !c_we_i) || (l_gnt && !l_we_i)) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

    assign c_gnt_o    = c_gnt;
    assign l_gnt_o    = l_gnt;
    assign c_stall_o  = c_req_i && !c_gnt && !rst_i;
    assign rdata_o    = rdata_q;
    assign c_rvalid_o = c_rvalid_q;
    assign l_rvalid_o = l_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data memory and a read scoreboard.
module tb_dmem_arbiter;

    localparam logic [2:0] CCtrl = 3'b010;
    localparam logic [2:0] LCtrl = 3'b101;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        c_req_i, c_we_i, l_req_i, l_lock_i, l_we_i;
    logic [31:0] c_addr_i, c_wdata_i, l_addr_i, l_wdata_i;
    logic [2:0]  c_ctrl_i, l_ctrl_i;
    logic        c_gnt_o, c_stall_o, l_gnt_o, c_rvalid_o, l_rvalid_o, mem_we_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [2:0]  mem_ctrl_o;

    typedef struct {
        logic        core;
        logic [31:0] data;
    } rd_t;

    rd_t         sb[$];
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    int          checks = 0;
    int          failures = 0;

    dmem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .CTRL_WIDTH (3),
        .MAX_HOLD   (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .c_req_i     (c_req_i),
        .c_we_i      (c_we_i),
        .c_addr_i    (c_addr_i),
        .c_wdata_i   (c_wdata_i),
        .c_ctrl_i    (c_ctrl_i),
        .c_gnt_o     (c_gnt_o),
        .c_stall_o   (c_stall_o),
        .l_req_i     (l_req_i),
        .l_lock_i    (l_lock_i),
        .l_we_i      (l_we_i),
        .l_addr_i    (l_addr_i),
        .l_wdata_i   (l_wdata_i),
        .l_ctrl_i    (l_ctrl_i),
        .l_gnt_o     (l_gnt_o),
        .rdata_o     (rdata_o),
        .c_rvalid_o  (c_rvalid_o),
        .l_rvalid_o  (l_rvalid_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_we_o    (mem_we_o),
        .mem_ctrl_o  (mem_ctrl_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural memory: combinational read, write at the clock edge
    assign mem_rdata_i = mem[mem_addr_o[9:2]];
    always @(posedge clk_i) begin
        if (mem_we_o) mem[mem_addr_o[9:2]] <= mem_wdata_o;
    end

    function automatic int unsigned widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // All outputs must be zero while reset is asserted
    task automatic check_reset_outputs(input string tag);
        check({tag, ":gnt"}, 32'({c_gnt_o, l_gnt_o}), 32'd0);
        check({tag, ":stall"}, 32'(c_stall_o), 32'd0);
        check({tag, ":rvalid"}, 32'({c_rvalid_o, l_rvalid_o}), 32'd0);
        check({tag, ":rdata"}, rdata_o, 32'd0);
        check({tag, ":mem_we"}, 32'(mem_we_o), 32'd0);
        check({tag, ":mem_addr"}, mem_addr_o, 32'd0);
        check({tag, ":mem_wdata"}, mem_wdata_o, 32'd0);
        check({tag, ":mem_ctrl"}, 32'(mem_ctrl_o), 32'd0);
    endtask

    task automatic set_idle();
        c_req_i = 0; c_we_i = 0; c_addr_i = 0; c_wdata_i = 0; c_ctrl_i = CCtrl;
        l_req_i = 0; l_lock_i = 0; l_we_i = 0; l_addr_i = 0; l_wdata_i = 0; l_ctrl_i = LCtrl;
    endtask

    // Reset with requests left active, check outputs, then release cleanly between edges
    task automatic do_reset(input string tag);
        c_req_i = 1; l_req_i = 1; l_lock_i = 1; c_addr_i = 32'h44; l_addr_i = 32'h88;
        rst_i = 1;
        #1;
        check_reset_outputs(tag);
        sb.delete();
        set_idle();
        @(negedge clk_i);
        rst_i = 0;
        @(posedge clk_i);
        #1;
    endtask

    // One cycle: drive, check read return and grant/mux, update scoreboard and reference memory
    task automatic cycle_run(input string tag,
                             input logic cr, input logic cw,
                             input logic [31:0] ca, input logic [31:0] cd,
                             input logic lr, input logic lk, input logic lw,
                             input logic [31:0] la, input logic [31:0] ld,
                             input logic egc, input logic egl);
        rd_t         e;
        logic [31:0] ea, ew;
        logic        ewe;
        logic [2:0]  ectl;
        c_req_i = cr; c_we_i = cw; c_addr_i = ca; c_wdata_i = cd; c_ctrl_i = CCtrl;
        l_req_i = lr; l_lock_i = lk; l_we_i = lw; l_addr_i = la; l_wdata_i = ld; l_ctrl_i = LCtrl;
        #2;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ":rvalid"}, 32'({c_rvalid_o, l_rvalid_o}), 32'({e.core, !e.core}));
            check({tag, ":rdata"}, rdata_o, e.data);
        end else begin
            check({tag, ":no_rvalid"}, 32'({c_rvalid_o, l_rvalid_o}), 32'd0);
        end
        check({tag, ":gnt"}, 32'({c_gnt_o, l_gnt_o}), 32'({egc, egl}));
        check({tag, ":stall"}, 32'(c_stall_o), 32'(cr & ~egc));
        ea = 0; ew = 0; ewe = 0; ectl = 0;
        if (egc) begin
            ea = ca; ew = cd; ewe = cw; ectl = CCtrl;
        end else if (egl) begin
            ea = la; ew = ld; ewe = lw; ectl = LCtrl;
        end
        check({tag, ":mem_addr"}, mem_addr_o, ea);
        check({tag, ":mem_wdata"}, mem_wdata_o, ew);
        check({tag, ":mem_we_ctrl"}, 32'({mem_we_o, mem_ctrl_o}), 32'({ewe, ectl}));
        if (egc || egl) begin
            if (ewe) begin
                ref_mem[widx(ea)] = ew;
            end else begin
                e.core = egc;
                e.data = ref_mem[widx(ea)];
                sb.push_back(e);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        rd_t e;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        set_idle();

        // Power-on reset
        do_reset("por");

        // Core read of 0x10, data back one cycle later
        cycle_run("core_rd", 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle_run("core_rd_ret", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Contention straight after reset: C, L, C, L
        do_reset("rst2");
        for (int i = 0; i < 4; i++) begin
            cycle_run("rr_tie", 1, 0, 32'h40 + 32'(4 * i), 0, 1, 0, 0, 32'h80 + 32'(4 * i), 0,
                      (i % 2) == 0, (i % 2) == 1);
        end
        cycle_run("rr_ret", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Locked writes 0x100..0x11C, core waiting from the second cycle: forced release
        for (int i = 0; i < 8; i++) begin
            cycle_run("lock_wr", i > 0, 0, 32'h10, 0, 1, 1, 1, 32'h100 + 32'(4 * i),
                      32'hF000_0100 + 32'(4 * i), 0, 1);
        end
        cycle_run("lock_force", 1, 0, 32'h10, 0, 1, 1, 1, 32'h120, 32'hF000_0120, 1, 0);
        cycle_run("lock_resume", 1, 0, 32'h14, 0, 1, 1, 1, 32'h120, 32'hF000_0120, 0, 1);
        cycle_run("lock_rel_core", 1, 0, 32'h14, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle_run("readback", 1, 0, 32'h104, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle_run("readback_ret", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Uncontested lock runs past the hold limit; a late core request still forces release
        for (int i = 0; i < 20; i++) begin
            cycle_run("lock_long", 0, 0, 0, 0, 1, 1, 0, 32'h200 + 32'(4 * i), 0, 0, 1);
        end
        cycle_run("sat_force", 1, 0, 32'h118, 0, 1, 1, 0, 32'h250, 0, 1, 0);

        // Lock drops in the same cycle the core asks: core granted immediately
        cycle_run("drop_a", 0, 0, 0, 0, 1, 1, 0, 32'h250, 0, 0, 1);
        cycle_run("drop_b", 0, 0, 0, 0, 1, 1, 0, 32'h254, 0, 0, 1);
        cycle_run("drop_core", 1, 0, 32'h20, 0, 1, 0, 0, 32'h258, 0, 1, 0);
        cycle_run("drop_ldr", 0, 0, 0, 0, 1, 0, 0, 32'h258, 0, 0, 1);
        cycle_run("drop_ret", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a lock, just after a loader read grant
        cycle_run("pre_rst", 0, 0, 0, 0, 1, 1, 0, 32'h30, 0, 0, 1);
        c_req_i = 1; c_addr_i = 32'h10; l_req_i = 1; l_lock_i = 1; l_addr_i = 32'h34;
        #1;
        e = sb.pop_front();
        check("pre_rst:rvalid", 32'({c_rvalid_o, l_rvalid_o}), 32'b01);
        check("pre_rst:rdata", rdata_o, e.data);
        do_reset("mid_lock");
        cycle_run("post_rst_tie", 1, 0, 32'h10, 0, 1, 1, 0, 32'h34, 0, 1, 0);
        cycle_run("post_rst_ldr", 0, 0, 0, 0, 1, 1, 0, 32'h34, 0, 0, 1);
        cycle_run("post_rst_ret", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
